// File: rtl/t_flip_flop.sv
// rtl/t_flip_flop.sv - parameterised bank of toggle flip-flops; optional toggle counter under TFF_TOGGLE_CNT_EN
module t_flip_flop #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] y
`ifdef TFF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  // Reject out-of-range configurations at elaboration rather than building odd hardware.
  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("t_flip_flop: WIDTH out of range 1..64");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("t_flip_flop: CNT_W out of range 2..32");
    end
  endgenerate

  // Each bit inverts where its toggle request is set; reset wins over t.
  always_ff @(posedge clock) begin
    if (!reset) begin
      y <= RESET_VAL;
    end else begin
      y <= y ^ t;
    end
  end

`ifdef TFF_TOGGLE_CNT_EN
  // Count edges where any bit toggled, sticking at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      toggle_cnt <= '0;
    end else if ((|t) && (toggle_cnt != {CNT_W{1'b1}})) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// tb/tb_t_flip_flop.sv - self-checking bench for t_flip_flop (directed plan plus randomized model check)
module tb_t_flip_flop;

  localparam logic [3:0] RV4 = 4'b1010;
  localparam logic [7:0] RV8 = 8'hA5;

  logic       clock;
  logic       reset;
  logic [0:0] t1, y1;
  logic [3:0] t4, y4;
  logic [7:0] t8, y8;
`ifdef TFF_TOGGLE_CNT_EN
  logic [1:0] cnt4;
  logic [3:0] cnt8;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state for the randomized instance: per-bit toggle tallies since reset.
  int flips[8];
  int n_toggle_edges;

  t_flip_flop #(.WIDTH(1)) u_dut1 (
    .clock(clock), .reset(reset), .t(t1), .y(y1)
`ifdef TFF_TOGGLE_CNT_EN
    , .toggle_cnt()
`endif
  );

  t_flip_flop #(.WIDTH(4), .RESET_VAL(RV4), .CNT_W(2)) u_dut4 (
    .clock(clock), .reset(reset), .t(t4), .y(y4)
`ifdef TFF_TOGGLE_CNT_EN
    , .toggle_cnt(cnt4)
`endif
  );

  t_flip_flop #(.WIDTH(8), .RESET_VAL(RV8), .CNT_W(4)) u_dut8 (
    .clock(clock), .reset(reset), .t(t8), .y(y8)
`ifdef TFF_TOGGLE_CNT_EN
    , .toggle_cnt(cnt8)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_y8();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = RV8[i] ^ flips[i][0];
    return r;
  endfunction

  initial begin
    logic [4:0] seq_t;
    logic [4:0] seq_y;
    logic [3:0] v;
    reset = 1'b1;
    t1 = '0; t4 = '0; t8 = '0;
    #2;

    // Reset dominates t on WIDTH=1.
    reset = 1'b0; t1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      chk("reset_hold", y1, 0);
    end
    reset = 1'b1; t1 = 1'b0;
    edge_step();
    chk("reset_release", y1, 0);

    // Hold/toggle sequence: t=1,0,1,1,0 -> y=1,1,0,1,1.
    seq_t = 5'b01101;
    seq_y = 5'b11011;
    for (int k = 0; k < 5; k++) begin
      t1 = seq_t[k];
      edge_step();
      chk("hold_toggle", y1, seq_y[k]);
    end

    // Bring y to 0, then divide-by-2 for 8 edges.
    t1 = 1'b1;
    edge_step();
    chk("div_pre", y1, 0);
    for (int k = 0; k < 8; k++) begin
      edge_step();
      chk("divider", y1, (k % 2 == 0) ? 1 : 0);
    end

    // Mid-operation reset.
    edge_step();
    chk("mid_pre", y1, 1);
    reset = 1'b0;
    edge_step();
    chk("mid_reset", y1, 0);
    reset = 1'b1;
    edge_step();
    chk("mid_resume", y1, 1);
    t1 = 1'b0;

    // Multi-bit with non-zero reset value.
    reset = 1'b0;
    edge_step();
    chk("mb_reset", y4, RV4);
`ifdef TFF_TOGGLE_CNT_EN
    chk("cnt_reset", cnt4, 0);
`endif
    reset = 1'b1;
    t4 = 4'b0110;
    edge_step();
    chk("mb_t0110", y4, 4'b1100);
    t4 = 4'b1111;
    edge_step();
    chk("mb_t1111", y4, 4'b0011);

    // Saturating counter (CNT_W=2): 1,2,3,3,3 then cleared by reset.
    reset = 1'b0; t4 = '0;
    edge_step();
    chk("mb_reset2", y4, RV4);
    reset = 1'b1;
    v = RV4;
    for (int k = 0; k < 5; k++) begin
      t4 = 4'($urandom_range(1, 15));
      v = v ^ t4;
      edge_step();
      chk("mb_rand", y4, v);
`ifdef TFF_TOGGLE_CNT_EN
      chk("cnt_sat", cnt4, (k + 1 > 3) ? 3 : k + 1);
`endif
    end
    t4 = 4'b0101;
    reset = 1'b0;
    edge_step();
    chk("mb_reset3", y4, RV4);
`ifdef TFF_TOGGLE_CNT_EN
    chk("cnt_clear", cnt4, 0);
`endif
    reset = 1'b1; t4 = '0;

    // Randomized run on WIDTH=8 against the tally model.
    reset = 1'b0;
    edge_step();
    for (int i = 0; i < 8; i++) flips[i] = 0;
    n_toggle_edges = 0;
    chk("rnd_reset", y8, RV8);
    for (int k = 0; k < 300; k++) begin
      reset = ($urandom_range(0, 15) != 0);
      t8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      edge_step();
      if (!reset) begin
        for (int i = 0; i < 8; i++) flips[i] = 0;
        n_toggle_edges = 0;
      end else begin
        for (int i = 0; i < 8; i++) if (t8[i]) flips[i]++;
        if (t8 != 0) n_toggle_edges++;
      end
      chk("rnd_y", y8, model_y8());
`ifdef TFF_TOGGLE_CNT_EN
      chk("rnd_cnt", cnt8, (n_toggle_edges > 15) ? 15 : n_toggle_edges);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t_flip_flop.md
Name: t_flip_flop

Overview:
- Parameterised bank of toggle (T) flip-flops.
- Each bit of output y inverts on a rising clock edge when its t bit is 1, and holds when t is 0.
- Used as a generic toggle/divide-by-2 storage element in behavioural datapaths and frequency dividers.
- Single clock domain with a synchronous active-low reset.

Parameters:
- WIDTH, 1, number of independent T flip-flops (bits of t and y); legal range 1..64.
- RESET_VAL, 0 (all zeros, WIDTH bits), value loaded into y on reset.
- CNT_W, 16, width of the optional toggle-event counter; legal range 2..32.

Ports:
- clock  input  1  rising-edge clock; all state updates on posedge clock.
- reset  input  1  synchronous active-low reset; sampled only on posedge clock.
- t  input  WIDTH  per-bit toggle request, sampled on posedge clock.
- y  output  WIDTH  registered flip-flop state.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. The clock port is named clock and the reset port is named reset.
- Reset: at posedge clock with reset==0, y <= RESET_VAL. Reset takes priority over t. A reset asserted between edges has no effect until the next edge; there is no asynchronous path.
- Normal operation: at posedge clock with reset==1, y <= y XOR t. Bits with t=1 invert and bits with t=0 hold.
- Latency: exactly one clock. A t value sampled at edge N is reflected in y immediately after edge N. y never changes between edges.
- Continuous toggling: t held all-ones makes each bit divide the clock by 2, giving period 2 clocks and 50% duty.
- Reset mid-operation: y returns to RESET_VAL on the first edge with reset low, regardless of t. Toggling resumes on the first edge with reset high.
- Power-up: y is undefined (X in simulation) until the first reset edge. No initial-value dependency is permitted.
- X/Z on t: no requirement. The bench must drive t to 0/1.
- y is driven only by the register, with no combinational path from t to y.

Optional Feature:
- Macro: TFF_TOGGLE_CNT_EN.
- Defined:
  - Adds output port toggle_cnt (output, CNT_W bits).
  - toggle_cnt counts clock edges at which reset==1 and t is non-zero, i.e. at least one bit toggled.
  - It saturates at all-ones (2^CNT_W - 1) and does not wrap.
  - It is cleared to 0 synchronously by the same active-low reset.
  - It updates on the same edge as y, with 1-cycle latency.
- Not defined: port toggle_cnt and its register are absent. The y behaviour is identical in both builds.

Test Plan:
- Reset: WIDTH=1, reset=0, t=1 for 3 edges -> y=0 after each edge; release reset with t=0 -> y stays 0.
- Hold/toggle: WIDTH=1, reset=1, y=0; apply t=1,0,1,1,0 on successive edges -> y=1,1,0,1,1.
- Divider: t=1 continuously for 8 edges from y=0 -> y alternates 1,0,1,0,1,0,1,0 (period 2 clocks).
- Mid-operation reset: y=1 with t=1; pull reset low for one edge -> y=0 on that edge; release with t=1 -> y=1 on the next edge.
- Multi-bit: WIDTH=4, RESET_VAL=4'b1010; after reset apply t=4'b0110 -> y=4'b1100, then t=4'b1111 -> y=4'b0011.
- Optional counter (TFF_TOGGLE_CNT_EN, CNT_W=2): 5 edges with t!=0 -> toggle_cnt=1,2,3,3,3 (saturates); one edge with reset=0 -> toggle_cnt=0.
